// File: rtl/multi_saikoro.sv
// Multi-die "saikoro" roller: odometer-chained dice that spin while roll is held,
// then decelerate over doubling intervals before latching the summed result.
module multi_saikoro #(
    parameter int NDICE      = 2,
    parameter int SLOW_STEPS = 4,
    parameter int SLOW_BASE  = 2,
    localparam int SW        = $clog2(6 * NDICE + 1)
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic                 roll,
    output logic [7*NDICE-1:0]   lamp,
    output logic [SW-1:0]        total,
    output logic                 done,
    output logic                 busy
);

    localparam int IW = $clog2((SLOW_BASE << SLOW_STEPS) + 1);
    localparam int KW = $clog2(SLOW_STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROLL = 2'd1;
    localparam logic [1:0] S_SLOW = 2'd2;
    localparam logic [1:0] S_SHOW = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [NDICE-1:0][2:0]  dice_q, dice_d, dice_adv;
    logic [KW-1:0]          k_q, k_d;
    logic [IW-1:0]          ivl_q, ivl_d, cnt_q, cnt_d;
    logic [SW-1:0]          total_q, total_d, sum_adv;
    logic                   carry;

    function automatic logic [6:0] pips(input logic [2:0] v);
        case (v)
            3'd1:    pips = 7'b0001000;
            3'd2:    pips = 7'b1000001;
            3'd3:    pips = 7'b0011100;
            3'd4:    pips = 7'b1010101;
            3'd5:    pips = 7'b1011101;
            3'd6:    pips = 7'b1110111;
            default: pips = 7'b0000000;
        endcase
    endfunction

    // Odometer advance: ripple the carry from die 0 upward; carry out of the top die is dropped.
    always_comb begin
        carry   = 1'b1;
        sum_adv = '0;
        for (int unsigned i = 0; i < NDICE; i++) begin
            dice_adv[i] = dice_q[i];
            if (carry) begin
                if (dice_q[i] == 3'd6) begin
                    dice_adv[i] = 3'd1;
                end else begin
                    dice_adv[i] = dice_q[i] + 3'd1;
                    carry       = 1'b0;
                end
            end
            sum_adv = sum_adv + SW'(dice_adv[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        dice_d  = dice_q;
        k_d     = k_q;
        ivl_d   = ivl_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        case (state_q)
            S_IDLE: begin
                if (roll) state_d = S_ROLL;
            end
            S_ROLL: begin
                dice_d = dice_adv;
                if (!roll) begin
                    state_d = S_SLOW;
                    k_d     = '0;
                    ivl_d   = IW'(SLOW_BASE);
                    cnt_d   = '0;
                end
            end
            S_SLOW: begin
                // A renewed roll request pre-empts any pending advance.
                if (roll) begin
                    state_d = S_ROLL;
                end else if (cnt_q == ivl_q - IW'(1)) begin
                    dice_d = dice_adv;
                    cnt_d  = '0;
                    k_d    = k_q + KW'(1);
                    ivl_d  = ivl_q << 1;
                    if (k_q == KW'(SLOW_STEPS - 1)) begin
                        state_d = S_SHOW;
                        total_d = sum_adv;
                    end
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dice_q  <= {NDICE{3'd1}};
            k_q     <= '0;
            ivl_q   <= '0;
            cnt_q   <= '0;
            total_q <= SW'(NDICE);
        end else begin
            state_q <= state_d;
            dice_q  <= dice_d;
            k_q     <= k_d;
            ivl_q   <= ivl_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        lamp = '0;
        for (int unsigned i = 0; i < NDICE; i++) begin
            lamp[7*i +: 7] = pips(dice_q[i]);
        end
    end

    assign total = total_q;
    assign done  = (state_q == S_SHOW);
    assign busy  = (state_q == S_ROLL) || (state_q == S_SLOW);

endmodule

// File: tb/tb_multi_saikoro.sv
// Bench for multi_saikoro: two instances (2-dice fast config, 3-dice config) checked
// against a behavioural model through per-instance expectation queues.
module tb_multi_saikoro;

    logic        ck;
    logic        reset;
    logic        roll0, roll1;
    logic [13:0] lamp0;
    logic [3:0]  total0;
    logic        done0, busy0;
    logic [20:0] lamp1;
    logic [4:0]  total1;
    logic        done1, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    multi_saikoro #(.NDICE(2), .SLOW_STEPS(2), .SLOW_BASE(1)) dut0 (
        .ck(ck), .reset(reset), .roll(roll0),
        .lamp(lamp0), .total(total0), .done(done0), .busy(busy0)
    );

    multi_saikoro #(.NDICE(3), .SLOW_STEPS(4), .SLOW_BASE(2)) dut1 (
        .ck(ck), .reset(reset), .roll(roll1),
        .lamp(lamp1), .total(total1), .done(done1), .busy(busy1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model state, index 0 = dut0, index 1 = dut1 (states: 0 IDLE,1 ROLL,2 SLOW,3 SHOW)
    int m_nd[2]    = '{2, 3};
    int m_steps[2] = '{2, 4};
    int m_base[2]  = '{1, 2};
    int m_st[2];
    int m_d[2][3];
    int m_k[2];
    int m_ivl[2];
    int m_cnt[2];
    int m_tot[2];

    logic [27:0] q0[$];
    logic [27:0] q1[$];

    function automatic logic [6:0] pips(input int v);
        case (v)
            1:       return 7'b0001000;
            2:       return 7'b1000001;
            3:       return 7'b0011100;
            4:       return 7'b1010101;
            5:       return 7'b1011101;
            6:       return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic m_reset(input int id);
        m_st[id] = 0; m_k[id] = 0; m_ivl[id] = 0; m_cnt[id] = 0;
        for (int i = 0; i < 3; i++) m_d[id][i] = 1;
        m_tot[id] = m_nd[id];
    endtask

    task automatic m_adv(input int id);
        for (int i = 0; i < m_nd[id]; i++) begin
            if (m_d[id][i] == 6) m_d[id][i] = 1;
            else begin m_d[id][i] = m_d[id][i] + 1; break; end
        end
    endtask

    task automatic m_step(input int id, input bit r);
        int s;
        case (m_st[id])
            0: if (r) m_st[id] = 1;
            1: begin
                m_adv(id);
                if (!r) begin m_st[id] = 2; m_k[id] = 0; m_ivl[id] = m_base[id]; m_cnt[id] = 0; end
            end
            2: begin
                if (r) m_st[id] = 1;
                else if (m_cnt[id] == m_ivl[id] - 1) begin
                    m_adv(id);
                    m_cnt[id] = 0; m_k[id]++; m_ivl[id] = m_ivl[id] * 2;
                    if (m_k[id] == m_steps[id]) begin
                        m_st[id] = 3;
                        s = 0;
                        for (int i = 0; i < m_nd[id]; i++) s += m_d[id][i];
                        m_tot[id] = s;
                    end
                end else m_cnt[id]++;
            end
            default: m_st[id] = 0;
        endcase
    endtask

    function automatic logic [27:0] m_out(input int id);
        logic [20:0] l;
        l = '0;
        for (int i = 0; i < m_nd[id]; i++) l[7*i +: 7] = pips(m_d[id][i]);
        return {l, 5'(m_tot[id]), 1'(m_st[id] == 3), 1'(m_st[id] == 1 || m_st[id] == 2)};
    endfunction

    // One clock: drive roll, push model expectation, sample after the edge and compare.
    task automatic tick(input bit r0, input bit r1);
        logic [27:0] e, g;
        roll0 = r0; roll1 = r1;
        m_step(0, r0); m_step(1, r1);
        q0.push_back(m_out(0));
        q1.push_back(m_out(1));
        @(posedge ck); #1;
        e = q0.pop_front();
        g = {7'b0, lamp0, 1'b0, total0, done0, busy0};
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL sb_dut0 t=%0t got=%h exp=%h", $time, g, e);
        end
        e = q1.pop_front();
        g = {lamp1, total1, done1, busy1};
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL sb_dut1 t=%0t got=%h exp=%h", $time, g, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; roll0 = 1'b0; roll1 = 1'b0;
        @(posedge ck); #3;
        reset = 1'b1;
        m_reset(0); m_reset(1);
        q0.delete(); q1.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; roll0 = 1'b0; roll1 = 1'b0;
        #12;
        n_tests++;
        if ({lamp0, total0, done0, busy0} !== {14'b0001000_0001000, 4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut0 got=%h exp=%h", {lamp0, total0, done0, busy0},
                     {14'b0001000_0001000, 4'd2, 1'b0, 1'b0});
        end
        n_tests++;
        if ({lamp1, total1, done1, busy1} !== {21'b0001000_0001000_0001000, 5'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut1 got=%h", {lamp1, total1, done1, busy1});
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            n_tests++;
            if ({lamp0, total0, done0, busy0} !== {14'b0001000_0001000, 4'd2, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_hold cyc=%0d got=%h", i, {lamp0, total0, done0, busy0});
            end
        end
    endtask

    task automatic test_single_roll();
        do_reset();
        tick(1, 0);
        tick(0, 0);
        n_tests++;
        if (lamp0[6:0] !== 7'b1000001 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL roll_c1 lamp0=%b busy=%b exp die0=2 busy=1", lamp0[6:0], busy0);
        end
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        n_tests++;
        if ({lamp0, total0, done0, busy0} !== {7'b0001000, 7'b1010101, 4'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL roll_show got=%h exp=%h", {lamp0, total0, done0, busy0},
                     {7'b0001000, 7'b1010101, 4'd5, 1'b1, 1'b0});
        end
        tick(0, 0);
        n_tests++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || total0 !== 4'd5) begin
            n_fail++;
            $display("FAIL roll_idle done=%b busy=%b total=%0d exp 0 0 5", done0, busy0, total0);
        end
        for (int i = 0; i < 3; i++) tick(0, 0);
    endtask

    task automatic test_odometer();
        do_reset();
        tick(1, 0);
        for (int i = 0; i < 17; i++) tick(1, 0);
        n_tests++;
        if (lamp0 !== {pips(3), pips(6)}) begin
            n_fail++;
            $display("FAIL odo_36 got=%b exp=%b", lamp0, {pips(3), pips(6)});
        end
        tick(1, 0);
        n_tests++;
        if (lamp0 !== {pips(4), pips(1)}) begin
            n_fail++;
            $display("FAIL odo_41 got=%b exp=%b", lamp0, {pips(4), pips(1)});
        end
        for (int i = 0; i < 17; i++) tick(1, 0);
        n_tests++;
        if (lamp0 !== {pips(6), pips(6)}) begin
            n_fail++;
            $display("FAIL odo_66 got=%b", lamp0);
        end
        tick(1, 0);
        n_tests++;
        if ({lamp0, total0, done0, busy0} !== {pips(1), pips(1), 4'd2, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL odo_wrap got=%h", {lamp0, total0, done0, busy0});
        end
        for (int i = 0; i < 6; i++) tick(0, 0);
    endtask

    task automatic test_reroll();
        int dones;
        do_reset();
        tick(1, 0); tick(1, 0); tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        n_tests++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reroll_busy busy=%b done=%b exp 1 0", busy0, done0);
        end
        tick(1, 0);
        tick(0, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            if (done0 === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL reroll_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        do_reset();
        tick(1, 0); tick(0, 0);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({lamp0, total0, done0, busy0} !== {14'b0001000_0001000, 4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", {lamp0, total0, done0, busy0},
                     {14'b0001000_0001000, 4'd2, 1'b0, 1'b0});
        end
        @(posedge ck); #3;
        reset = 1'b1;
        m_reset(0); m_reset(1);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0);
            if (done0 === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL async_no_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_three_dice();
        int chg[$];
        logic [20:0] prev;
        int exp_at[4] = '{2, 6, 14, 30};
        bit seen_done;
        do_reset();
        tick(0, 1);
        for (int i = 0; i < 216; i++) tick(0, 1);
        n_tests++;
        if (lamp1 !== 21'b0001000_0001000_0001000 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL three_wrap lamp=%b busy=%b", lamp1, busy1);
        end
        tick(0, 0);
        prev = lamp1;
        seen_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick(0, 0);
            if (lamp1 !== prev) chg.push_back(i);
            if (done1 === 1'b1) seen_done = 1'b1;
            prev = lamp1;
        end
        n_tests++;
        if (chg.size() !== 4) begin
            n_fail++;
            $display("FAIL three_adv_count got=%0d exp=4", chg.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (chg[i] !== exp_at[i]) begin
                    n_fail++;
                    $display("FAIL three_adv_time idx=%0d got=%0d exp=%0d", i, chg[i], exp_at[i]);
                end
            end
        end
        n_tests++;
        if (total1 !== 5'd8 || !seen_done) begin
            n_fail++;
            $display("FAIL three_total got=%0d done_seen=%0b exp=8 1", total1, seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_roll();
        test_odometer();
        test_reroll();
        test_async_reset();
        test_three_dice();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
